// File: rtl/alu_main_reg.sv
// Two-operand AND/OR/ADD/SUB ALU with NZCV flags, registered with one-cycle latency.
// Accepts one operation per cycle on in_valid; there is no backpressure.
module alu_main_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A_num,
  input  logic [WIDTH-1:0] B_num,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] result,
  output logic             N_flag,
  output logic             Z_flag,
  output logic             C_flag,
  output logic             V_flag,
  output logic             out_valid
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_new;
  logic             c_new;
  logic             v_new;

  // ADD and SUB share one adder: SUB inverts B and injects carry-in through ALUControl[0].
  always_comb begin
    b_op = ALUControl[0] ? ~B_num : B_num;
    sum  = {1'b0, A_num} + {1'b0, b_op} + {{WIDTH{1'b0}}, ALUControl[0]};
  end

  always_comb begin
    res_new = '0;
    c_new   = 1'b0;
    v_new   = 1'b0;
    case (ALUControl)
      2'b00: res_new = A_num & B_num;
      2'b01: res_new = A_num | B_num;
      default: begin
        res_new = sum[WIDTH-1:0];
        c_new   = sum[WIDTH];
        // b_op already holds ~B for SUB, so one sign-compare covers both cases.
        v_new   = (A_num[MSB] == b_op[MSB]) && (res_new[MSB] != A_num[MSB]);
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = res_new;
      n_d         = res_new[MSB];
      z_d         = (res_new == '0);
      c_d         = c_new;
      v_d         = v_new;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign N_flag    = n_q;
  assign Z_flag    = z_q;
  assign C_flag    = c_q;
  assign V_flag    = v_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_main_reg.sv
// Directed-vector bench for alu_main_reg at WIDTH=4.
module tb_alu_main_reg;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] A_num;
  logic [WIDTH-1:0] B_num;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] result;
  logic             N_flag, Z_flag, C_flag, V_flag;
  logic             out_valid;

  int n_applied;
  int n_miscompares;

  typedef struct {
    logic [1:0] ctrl;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] nzcv;
  } vec_t;

  vec_t vecs[12];

  alu_main_reg #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .A_num      (A_num),
    .B_num      (B_num),
    .ALUControl (ALUControl),
    .result     (result),
    .N_flag     (N_flag),
    .Z_flag     (Z_flag),
    .C_flag     (C_flag),
    .V_flag     (V_flag),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {out_valid, result, N, Z, C, V} against the expected packing.
  task automatic check(input string name, input logic exp_vld,
                       input logic [3:0] exp_res, input logic [3:0] exp_nzcv);
    logic [8:0] got, exp;
    got = {out_valid, result, N_flag, Z_flag, C_flag, V_flag};
    exp = {exp_vld, exp_res, exp_nzcv};
    n_applied++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got vld=%b res=%b nzcv=%b, expected vld=%b res=%b nzcv=%b",
               name, got[8], got[7:4], got[3:0], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_applied     = 0;
    n_miscompares = 0;

    //             ctrl   a        b        res      nzcv
    vecs[0]  = '{2'b00, 4'b0111, 4'b0010, 4'b0010, 4'b0000};
    vecs[1]  = '{2'b01, 4'b1111, 4'b1111, 4'b1111, 4'b1000};
    vecs[2]  = '{2'b10, 4'b1110, 4'b1110, 4'b1100, 4'b1010};
    vecs[3]  = '{2'b11, 4'b1111, 4'b0111, 4'b1000, 4'b1010};
    vecs[4]  = '{2'b11, 4'b0101, 4'b0101, 4'b0000, 4'b0110};
    vecs[5]  = '{2'b10, 4'b0111, 4'b0001, 4'b1000, 4'b1001};
    vecs[6]  = '{2'b11, 4'b1000, 4'b0001, 4'b0111, 4'b0011};
    vecs[7]  = '{2'b11, 4'b0001, 4'b0010, 4'b1111, 4'b1000};
    vecs[8]  = '{2'b10, 4'b1000, 4'b1000, 4'b0000, 4'b0111};
    vecs[9]  = '{2'b00, 4'b1010, 4'b0101, 4'b0000, 4'b0100};
    vecs[10] = '{2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0110};
    vecs[11] = '{2'b10, 4'b1111, 4'b0001, 4'b0000, 4'b0110};

    // Reset with a live operation presented: reset must win.
    rst        = 1'b1;
    in_valid   = 1'b1;
    A_num      = 4'b0111;
    B_num      = 4'b0001;
    ALUControl = 2'b10;
    step();
    check("reset_cycle0", 1'b0, 4'b0000, 4'b0000);
    step();
    check("reset_cycle1", 1'b0, 4'b0000, 4'b0000);
    rst = 1'b0;

    // Back-to-back: in_valid held high across the whole table.
    for (int i = 0; i < 12; i++) begin
      in_valid   = 1'b1;
      ALUControl = vecs[i].ctrl;
      A_num      = vecs[i].a;
      B_num      = vecs[i].b;
      step();
      check($sformatf("vec%0d", i), 1'b1, vecs[i].res, vecs[i].nzcv);
    end

    // Hold: in_valid low with changed operands must not disturb outputs.
    in_valid   = 1'b0;
    ALUControl = 2'b01;
    A_num      = 4'b1010;
    B_num      = 4'b0101;
    step();
    check("hold_cycle0", 1'b0, 4'b0000, 4'b0110);
    step();
    check("hold_cycle1", 1'b0, 4'b0000, 4'b0110);

    // Single op after idle, then reset mid-stream while in_valid stays high.
    in_valid   = 1'b1;
    ALUControl = 2'b01;
    A_num      = 4'b1010;
    B_num      = 4'b0100;
    step();
    check("op_after_idle", 1'b1, 4'b1110, 4'b1000);
    rst        = 1'b1;
    ALUControl = 2'b10;
    A_num      = 4'b0011;
    B_num      = 4'b0011;
    step();
    check("midstream_reset", 1'b0, 4'b0000, 4'b0000);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_reset_idle", 1'b0, 4'b0000, 4'b0000);

    // Recovery: first op after reset appears with one-cycle latency.
    in_valid   = 1'b1;
    ALUControl = 2'b11;
    A_num      = 4'b0011;
    B_num      = 4'b0100;
    step();
    check("recover_sub", 1'b1, 4'b1111, 4'b1000);
    in_valid = 1'b0;
    step();
    check("recover_hold", 1'b0, 4'b1111, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule

// File: doc/alu_main_reg.md
Name: alu_main_reg

Overview:
- Parameterised two-operand integer ALU: AND, OR, ADD, SUB selected by a 2-bit control, plus ARM-style NZCV status flags.
- Inputs are sampled on a valid strobe; result and flags are registered with fixed one-cycle latency.
- Serves as the datapath execute unit of the processor core; feeds the writeback and condition-flag logic.

Parameters:
WIDTH, 4, operand and result width in bits (legal range >= 2)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  A_num/B_num/ALUControl valid this cycle; sampled on rising clk
A_num  input  WIDTH  operand A (two's complement for V/N interpretation)
B_num  input  WIDTH  operand B
ALUControl  input  2  00 AND, 01 OR, 10 ADD, 11 SUB (A - B)
result  output  WIDTH  registered operation result
N_flag  output  1  registered negative flag
Z_flag  output  1  registered zero flag
C_flag  output  1  registered carry / not-borrow flag
V_flag  output  1  registered signed-overflow flag
out_valid  output  1  high for one cycle when result/flags hold a new value

Behaviour:
- Reset: rst high at a rising edge clears result=0, N=Z=C=V=0, out_valid=0. Reset takes priority over in_valid in the same cycle; an operation presented with rst is discarded.
- Latency: inputs sampled at edge k with in_valid=1 appear on result/flags at edge k (visible in cycle k+1). out_valid=1 for that cycle.
- Hold: in_valid=0 leaves result and flags holding their last value; out_valid drops to 0 next edge.
- Back-to-back: in_valid may be high every cycle; throughput one op/cycle; no backpressure.
- Operations, computed on a WIDTH+1-bit internal sum:
  - 00: result = A & B; C=0, V=0.
  - 01: result = A | B; C=0, V=0.
  - 10: {C,result} = A + B.
    - V = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
  - 11: {C,result} = A + ~B + 1.
    - C=1 means no borrow (A >= B unsigned).
    - V = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
- N = result[WIDTH-1] for all ops; Z = (result == 0) for all ops.
- All results wrap modulo 2^WIDTH; no saturation.
- Flags are always updated together with result; no partial flag update.
- No X propagation: all outputs are defined from reset onward.
- The ADD/SUB datapath is shared: one adder with a conditional B inversion and carry-in = ALUControl[0].

Test Plan:
- rst=1 for 2 cycles with in_valid=1 and arbitrary operands -> result=0000, NZCV=0000, out_valid=0. Then release rst.
- AND: A=0111, B=0010, ctrl=00 -> next cycle result=0010, N0 Z0 C0 V0, out_valid=1.
- OR: A=1111, B=1111, ctrl=01 -> result=1111, N1 Z0 C0 V0. ADD: A=1110, B=1110, ctrl=10 -> result=1100, N1 Z0 C1 V0.
- SUB: A=1111, B=0111, ctrl=11 -> result=1000, N1 Z0 C1 V0. SUB: A=0101, B=0101 -> result=0000, Z1 C1 N0 V0.
- Overflow and borrow:
  - ADD A=0111, B=0001 -> result=1000, N1 C0 V1.
  - SUB A=1000, B=0001 -> result=0111, N0 C1 V1.
  - SUB A=0001, B=0010 -> result=1111, N1 C0 V0.
- Hold and back-to-back:
  - Four consecutive ops with in_valid=1 each cycle -> four consecutive out_valid pulses with matching results.
  - in_valid=0 next -> outputs hold the last values, out_valid=0.
  - Asserting rst mid-stream clears outputs at that edge.
